fu_mul_pipe: RTL and testbench
==============================

// Module: fu_mul_pipe
// PURPOSE
//  Pipelined RV32M multiply functional unit for the out-of-order core; replaces the single-issue
//  multi-cycle multiplier. Accepts one op per cycle, supports MUL/MULH/MULHSU/MULHU, carries
//  a reservation-station tag to the result, and holds results under common-data-bus back-pressure.
// PARAMETERS
//  XLEN     32  operand/result width
//  LATENCY  7   cycles from accept to finish; legal range 2..16
//  TAG_W    3   reservation-station tag width
// PORTS
//  clk      in   1        clock, rising edge
//  rst      in   1        synchronous, active-high reset
//  flush    in   1        synchronous kill of all in-flight ops (branch mispredict)
//  EN       in   1        issue request; op accepted when EN & ready at posedge
//  op       in   2        00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  A, B     in   XLEN     operands (rs1, rs2)
//  tag_in   in   TAG_W    issuing reservation-station tag
//  ready    out  1        pipeline advances this cycle; EN ignored when 0
//  res      out  XLEN     result of oldest completed op
//  tag_out  out  TAG_W    tag of res
//  finish   out  1        res/tag_out valid
//  ack      in   1        CDB accepted res this cycle
// BEHAVIOUR
//  - One clock; reset synchronous active-high. On rst: all stage valids 0; finish=0, res=0, tag_out=0.
//  - Pipeline: LATENCY stages, each with valid, op, tag, data. Stage 1 captures operands;
//    stage LATENCY is the output register driving res/tag_out/finish.
//  - Latency: op accepted at edge t -> finish=1 after edge t+LATENCY-1 (LATENCY cycles incl. issue cycle
//    being cycle 1 after accept... precisely: finish rises LATENCY edges after accept edge counting accept).
//    LATENCY=7: accept at edge 0, finish visible after edge 6, held through cycle 7 if no ack.
//  - Throughput: 1 op/cycle; back-to-back accepts produce back-to-back finishes when ack=1.
//  - Back-pressure: advance = ~finish | ack; ready = advance. When advance=0 all stages freeze;
//    res/tag_out/finish stable until ack. ack while finish=0 ignored.
//  - EN & ~ready: op not accepted; issuer holds it. No bubble squeezing (whole pipe stalls).
//  - flush: clears every valid incl. output on next edge; finish=0 next cycle; EN same cycle dropped.
//    flush beats ack, EN and stall. rst beats flush. Data regs need not clear on flush.
//  - rst mid-operation: all in-flight ops lost, outputs to reset values next cycle.
//  - Arithmetic: extend A to XLEN+1 bits signed for MULH/MULHSU, zero otherwise; B signed only for MULH.
//    Product is (2*XLEN+2)-bit signed. MUL -> P[XLEN-1:0]; MULH/MULHSU/MULHU -> P[2*XLEN-1:XLEN].
//    Product computed in stage 2 as a single multiply followed by LATENCY-2 register stages
//    (retiming-friendly); for LATENCY=2 the product registers directly into the output stage.
//  - Op/tag of invalid stages are don't-care; finish is driven only from output-stage valid.
// STRUCTURE
//  - Shared package (core pkg): MUL op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU), op width,
//    default FU latencies used by the issue logic's scoreboard.
//  - One sub-module: fu_pipe_reg (parametrised width, en, rst, flush-on-valid) instantiated per stage;
//    reusable by the divider and FP units.
// TESTING
//  - MUL 7*6, tag 3, ack=1 -> finish after LATENCY cycles, res=0x0000002A, tag_out=3, 1 cycle.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
//  - Issue 3 ops back-to-back (tags 1,2,3), ack=1 -> finish high 3 consecutive cycles, tags 1,2,3.
//  - Same 3 ops, ack=0 for 4 cycles at first finish -> ready=0, res/tag_out=tag1 stable, no op lost;
//    then ack=1 -> tags 1,2,3 in order, ready returns 1.
//  - Flush 3 cycles after issuing 2 ops, with EN=1 same cycle -> finish never rises for any of them;
//    op issued the cycle after flush completes normally.
//  - rst asserted mid-flight with finish=1 -> next cycle finish=0, res=0, tag_out=0, ready=1.

Source files
------------

// File: rtl/fu_mul_pipe_pkg.sv
// Shared core definitions for the multiply functional unit: op encodings,
// operand-signedness helpers and the default FU latencies used by issue scoreboarding.
package fu_mul_pipe_pkg;

  localparam int unsigned MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  // Default functional-unit latencies seen by the issue logic
  localparam int unsigned FU_LAT_ALU = 1;
  localparam int unsigned FU_LAT_MUL = 7;
  localparam int unsigned FU_LAT_DIV = 34;

  function automatic logic mul_a_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic mul_b_signed(input mul_op_e op);
    return (op == MUL_OP_MULH);
  endfunction

  function automatic logic mul_takes_high(input mul_op_e op);
    return (op != MUL_OP_MUL);
  endfunction

endpackage

// File: rtl/fu_mul_pipe_reg.sv
// Generic pipeline stage register: valid bit plus payload, advanced by en,
// valid killed by flush; shared by the multiply, divide and FP pipelines.
module fu_pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  output logic [W-1:0] data_out
);

  // Flush drops only the valid; payload of a dead stage is don't-care
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (en) begin
      valid_out <= valid_in;
      data_out  <= data_in;
    end
  end

endmodule

// File: rtl/fu_mul_pipe.sv
// Pipelined RV32M multiply unit: one op per cycle, tag carried to the result,
// whole pipe freezes while a finished result waits for the CDB.
module fu_mul_pipe
  import fu_mul_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = FU_LAT_MUL,
  parameter int unsigned TAG_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                EN,
  input  logic [MUL_OP_W-1:0] op,
  input  logic [XLEN-1:0]     A,
  input  logic [XLEN-1:0]     B,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                ready,
  output logic [XLEN-1:0]     res,
  output logic [TAG_W-1:0]    tag_out,
  output logic                finish,
  input  logic                ack
);

  localparam int unsigned PROD_W = 2 * XLEN;

  typedef struct packed {
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } opnd_t;

  typedef struct packed {
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
    logic [PROD_W-1:0] prod;
  } prod_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
  } out_t;

  logic  advance;
  opnd_t s1_in;
  opnd_t s1_q;
  logic  s1_valid;
  prod_t prod1;
  prod_t mid_d [1:LATENCY-1];
  logic  mid_v [1:LATENCY-1];
  out_t  out_in;
  out_t  out_q;

  logic [XLEN:0]     a_ext;
  logic [XLEN:0]     b_ext;
  logic [PROD_W-1:0] a_wide;
  logic [PROD_W-1:0] b_wide;

  // Entire pipe moves unless a finished result is still waiting for the CDB
  assign advance = ~finish | ack;
  assign ready   = advance;

  always_comb begin
    s1_in     = '0;
    s1_in.op  = mul_op_e'(op);
    s1_in.tag = tag_in;
    s1_in.a   = A;
    s1_in.b   = B;
  end

  fu_pipe_reg #(.W($bits(opnd_t))) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .en        (advance),
    .valid_in  (EN),
    .data_in   (s1_in),
    .valid_out (s1_valid),
    .data_out  (s1_q)
  );

  // Only the low 2*XLEN bits of the (XLEN+1)x(XLEN+1) signed product are ever
  // selected, so a 2*XLEN modular multiply of the extended operands is exact
  always_comb begin
    a_ext      = {mul_a_signed(s1_q.op) & s1_q.a[XLEN-1], s1_q.a};
    b_ext      = {mul_b_signed(s1_q.op) & s1_q.b[XLEN-1], s1_q.b};
    a_wide     = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
    b_wide     = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    prod1      = '0;
    prod1.op   = s1_q.op;
    prod1.tag  = s1_q.tag;
    prod1.prod = a_wide * b_wide;
  end

  assign mid_v[1] = s1_valid;
  assign mid_d[1] = prod1;

  // Plain register stages after the multiply give synthesis room to retime it
  for (genvar k = 2; k < LATENCY; k++) begin : g_mid
    fu_pipe_reg #(.W($bits(prod_t))) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .en        (advance),
      .valid_in  (mid_v[k-1]),
      .data_in   (mid_d[k-1]),
      .valid_out (mid_v[k]),
      .data_out  (mid_d[k])
    );
  end

  always_comb begin
    out_in     = '0;
    out_in.tag = mid_d[LATENCY-1].tag;
    out_in.res = mul_takes_high(mid_d[LATENCY-1].op) ? mid_d[LATENCY-1].prod[PROD_W-1:XLEN]
                                                     : mid_d[LATENCY-1].prod[XLEN-1:0];
  end

  fu_pipe_reg #(.W($bits(out_t))) u_stage_out (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .en        (advance),
    .valid_in  (mid_v[LATENCY-1]),
    .data_in   (out_in),
    .valid_out (finish),
    .data_out  (out_q)
  );

  assign res     = out_q.res;
  assign tag_out = out_q.tag;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Directed + randomized scoreboard bench for fu_mul_pipe.
module tb_fu_mul_pipe;

  localparam int unsigned LAT = 7;

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] res;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        EN;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  tag_in;
  logic        ready;
  logic [31:0] res;
  logic [2:0]  tag_out;
  logic        finish;
  logic        ack;

  exp_t        exp_q[$];
  logic [31:0] nxt_exp;
  int          checks;
  int          errors;

  fu_mul_pipe #(.XLEN(32), .LATENCY(LAT), .TAG_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .EN      (EN),
    .op      (op),
    .A       (A),
    .B       (B),
    .tag_in  (tag_in),
    .ready   (ready),
    .res     (res),
    .tag_out (tag_out),
    .finish  (finish),
    .ack     (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] sx;
    logic signed [65:0] sy;
    logic signed [65:0] p;
    sx = (o == 2'b01 || o == 2'b10) ? {{34{x[31]}}, x} : {34'd0, x};
    sy = (o == 2'b01) ? {{34{y[31]}}, y} : {34'd0, y};
    p  = sx * sy;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", name, obs, expv);
    end
  endtask

  // Sample before the edge, update scoreboard, then advance one cycle
  task automatic step();
    exp_t e;
    #1;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        chk("no_spurious_finish", 32'(finish), 32'd0);
      end else if (finish && ack) begin
        e = exp_q.pop_front();
        chk("res", res, e.res);
        chk("tag_out", 32'(tag_out), 32'(e.tag));
      end
      if (EN && ready) begin
        e.tag = tag_in;
        e.res = nxt_exp;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] t, input logic [31:0] expv);
    EN = 1'b1; op = o; A = x; B = y; tag_in = t; nxt_exp = expv;
    step();
    EN = 1'b0;
  endtask

  task automatic wait_finish(input int max_cyc);
    int n;
    n = 0;
    while (!finish && n < max_cyc) begin
      step();
      n++;
    end
    chk("wait_finish", 32'(finish), 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; flush = 1'b0; EN = 1'b0; op = 2'b00; A = '0; B = '0;
    tag_in = '0; ack = 1'b1; nxt_exp = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("reset_finish", 32'(finish), 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_tag", 32'(tag_out), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);

    // Single MUL: latency and one-cycle finish
    issue(2'b00, 32'd7, 32'd6, 3'd3, 32'h0000002A);
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      chk("latency_low", 32'(finish), 32'd0);
      step();
    end
    chk("latency_high", 32'(finish), 32'd1);
    chk("mul_tag", 32'(tag_out), 32'd3);
    step();
    chk("finish_one_cycle", 32'(finish), 32'd0);

    // Corner operands, back to back
    issue(2'b01, 32'h80000000, 32'h80000000, 3'd4, 32'h40000000);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'hFFFFFFFE);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd6, 32'hFFFFFFFF);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 32'h00000001);
    drain(20);

    // Three back-to-back ops, ack held high
    issue(2'b00, 32'd3, 32'd5, 3'd1, 32'd15);
    issue(2'b00, 32'd9, 32'd9, 3'd2, 32'd81);
    issue(2'b00, 32'd100, 32'd3, 3'd3, 32'd300);
    wait_finish(20);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_finish", 32'(finish), 32'd1);
      chk("b2b_tag", 32'(tag_out), 32'(i + 1));
      step();
    end
    chk("b2b_done", 32'(finish), 32'd0);

    // Same ops under back-pressure; a held issue request must not slip in
    issue(2'b00, 32'd3, 32'd5, 3'd1, 32'd15);
    issue(2'b00, 32'd9, 32'd9, 3'd2, 32'd81);
    issue(2'b00, 32'd100, 32'd3, 3'd3, 32'd300);
    ack = 1'b0;
    wait_finish(20);
    EN = 1'b1; op = 2'b11; A = 32'hDEADBEEF; B = 32'h12345678; tag_in = 3'd4;
    nxt_exp = model(2'b11, 32'hDEADBEEF, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      chk("stall_ready", 32'(ready), 32'd0);
      chk("stall_finish", 32'(finish), 32'd1);
      chk("stall_tag", 32'(tag_out), 32'd1);
      chk("stall_res", res, 32'd15);
      step();
    end
    ack = 1'b1;
    step();
    EN = 1'b0;
    chk("stall_ready_back", 32'(ready), 32'd1);
    chk("stall_next_tag", 32'(tag_out), 32'd2);
    drain(20);

    // Flush kills in-flight ops and the same-cycle issue
    issue(2'b00, 32'd11, 32'd11, 3'd1, 32'd121);
    issue(2'b00, 32'd12, 32'd12, 3'd2, 32'd144);
    step();
    step();
    flush = 1'b1;
    EN = 1'b1; op = 2'b00; A = 32'd13; B = 32'd13; tag_in = 3'd6; nxt_exp = 32'd169;
    step();
    flush = 1'b0;
    EN = 1'b0;
    chk("flush_finish", 32'(finish), 32'd0);
    issue(2'b01, 32'hFFFFFFFE, 32'd5, 3'd7, 32'hFFFFFFFF);
    drain(20);
    for (int i = 0; i < 4; i++) step();

    // Reset while a result is waiting
    issue(2'b00, 32'd2, 32'd2, 3'd1, 32'd4);
    issue(2'b00, 32'd3, 32'd3, 3'd2, 32'd9);
    issue(2'b00, 32'd4, 32'd4, 3'd3, 32'd16);
    ack = 1'b0;
    wait_finish(20);
    rst = 1'b1;
    step();
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    ack = 1'b1;

    // Random ops with random back-pressure
    for (int i = 0; i < 80; i++) begin
      EN = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      A = $urandom;
      B = $urandom;
      tag_in = 3'($urandom_range(0, 7));
      nxt_exp = model(op, A, B);
      ack = 1'($urandom_range(0, 1));
      step();
    end
    EN = 1'b0;
    ack = 1'b1;
    drain(64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
